cw_encode_ctrl: RTL
===================

// Module: cw_encode_ctrl
// PURPOSE
//  Sequencer for encoder_main (constant-weight encoder of the Niederreiter encryptor).
//  Buffers host message bytes, serialises them MSB-first onto encoder bin_msg/readfifo,
//  pulses start, captures each cw_word on ready and accumulates it into an error position.
//  Stores T positions in a readback RAM and reports done/error to the top-level FSM.
// PARAMETERS
//  T           27    codeword weight = number of cw_words per run
//  MSG_DEPTH   16    message byte FIFO depth (power of 2)
//  WDOG_CYC    4096  stall timeout in cycles (WDOG_EN only)
// PORTS
//  clk          in   1   clock, all logic on posedge
//  rst_b        in   1   asynchronous active-low reset
//  msg_valid    in   1   host byte valid
//  msg_data     in   8   host byte, bit 7 sent first
//  msg_ready    out  1   byte FIFO not full; byte accepted when msg_valid&msg_ready
//  go           in   1   start a run (sampled in IDLE only)
//  busy         out  1   run in progress (START..WAIT_DONE)
//  done         out  1   1-cycle pulse, run completed
//  error        out  1   sticky, cleared by next accepted go
//  rd_addr      in   5   position RAM read index 0..T-1
//  rd_data      out  11  position at rd_addr, registered, 1-cycle latency
//  enc_start    out  1   to encoder_main.start
//  enc_bin_msg  out  1   to encoder_main.bin_msg: head bit of serialiser
//  enc_fifoempty out 1   to encoder_main.fifoempty: no bit available
//  enc_readfifo in   1   from encoder_main.readfifo: pop one bit
//  enc_cw_word  in   11  from encoder_main.cw_word
//  enc_ready    in   1   from encoder_main.ready: cw_word valid this cycle
//  enc_done     in   1   from encoder_main.done
// BEHAVIOUR
//  Reset: state IDLE; msg_ready=1, busy=0, done=0, error=0, enc_start=0, enc_fifoempty=1,
//   enc_bin_msg=0, rd_data=0; FIFO empty, bit index 7, word count 0, pos_acc=0x7FF.
//  Byte FIFO accepts bytes in every state (streaming during run); full -> msg_ready=0.
//  Serialiser: shift reg holds current byte; enc_bin_msg = bit[idx]; enc_fifoempty=1 when
//   shift reg empty and FIFO empty. Pop on enc_readfifo: idx-- ; at idx 0 reload next
//   FIFO byte same edge (no bubble if FIFO non-empty). Pop while enc_fifoempty=1: ignored,
//   error<=1.
//  FSM:
//   IDLE: go -> START; clears count, pos_acc=0x7FF, error. go while busy ignored.
//   START: enc_start=1 for exactly one cycle -> RUN.
//   RUN: on enc_ready: pos = pos_acc + enc_cw_word + 1 (11-bit, mod 2048); write RAM[count],
//    pos_acc<=pos, count++. Carry out of bit 10 -> error<=1 (position overflow).
//    count reaches T -> WAIT_DONE. enc_done with count<T -> error<=1, -> FIN.
//   WAIT_DONE: enc_done -> FIN; further enc_ready -> error<=1, not stored.
//   FIN: done=1 one cycle; leftover serialiser bits discarded; -> IDLE.
//  enc_ready and enc_done same cycle: word captured first, then done evaluated.
//  Latency: go -> enc_start 1 cycle; last enc_done -> done 1 cycle.
//  rd_addr >= T returns 0. RAM readable in any state; writes only in RUN.
//  Async reset mid-run: all state reset, FIFO flushed, RAM contents undefined.
// CONFIGURATION
//  CW_CTRL_WDOG_EN defined: counter reset on every enc_readfifo/enc_ready; in RUN or
//   WAIT_DONE reaching WDOG_CYC -> error<=1, -> FIN (done pulses). Also stalls on empty FIFO.
//  Undefined: no counter; controller waits indefinitely for encoder/message.
// TESTING
//  1 Load 16 bytes 0xFF.., go -> enc_start 1 cycle after go, busy=1, bits popped MSB-first.
//  2 Model encoder returns cw_word 0,4,10 ... 27 words -> rd_data[0]=0,[1]=5,[2]=16; done 1 cycle.
//  3 FIFO full (16 bytes) -> msg_ready=0; extra byte not accepted; pop frees slot next cycle.
//  4 enc_readfifo with empty FIFO -> error=1 sticky until next go; pos cw_word sum >2047 -> error.
//  5 enc_done after 10 words -> error=1, done pulse, busy=0; go clears error.
//  6 WDOG_EN, WDOG_CYC=64, FIFO empty in RUN -> error=1 and done at cycle 64; rst_b low mid-run -> IDLE.

Source files
------------

// File: rtl/cw_encode_ctrl.sv
// cw_encode_ctrl: sequencer wrapped around encoder_main, the constant-weight encoder.
// Host bytes are buffered in a small FIFO and fed MSB-first to the encoder one bit per
// readfifo pop. The controller pulses enc_start, turns every returned cw_word into an
// absolute error position (a running sum of gap+1), and stores the T positions in a
// readback RAM. It reports done and a sticky error to the surrounding FSM.
// Optional feature: define CW_CTRL_WDOG_EN to enable a stall watchdog of WDOG_CYC cycles.
module cw_encode_ctrl #(
  parameter int T         = 27,
  parameter int MSG_DEPTH = 16,
  parameter int WDOG_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        msg_valid,
  input  logic [7:0]  msg_data,
  output logic        msg_ready,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [4:0]  rd_addr,
  output logic [10:0] rd_data,
  output logic        enc_start,
  output logic        enc_bin_msg,
  output logic        enc_fifoempty,
  input  logic        enc_readfifo,
  input  logic [10:0] enc_cw_word,
  input  logic        enc_ready,
  input  logic        enc_done
);

  localparam int PW = $clog2(MSG_DEPTH);
  localparam int CW = $clog2(T + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_WAIT_DONE,
    ST_FIN
  } state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic            r_enc_start;
  logic [CW-1:0]   r_count;
  logic [10:0]     r_pos_acc;
  logic [10:0]     r_rd_data;
  logic [10:0]     r_ram [T];

  logic [7:0]      r_fifo [MSG_DEPTH];
  logic [PW:0]     r_wr_ptr;
  logic [PW:0]     r_rd_ptr;

  logic [7:0]      r_shift;
  logic [2:0]      r_idx;
  logic            r_sh_valid;

  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic            w_push;
  logic            w_fifo_pop;
  logic [7:0]      w_head;
  logic            w_bit_avail;
  logic            w_pop_ok;
  logic            w_pop_err;
  logic [11:0]     w_sum;
  logic            w_overflow;
  logic            w_last;
  logic            w_ram_we;
  logic            w_wdog_expire;

  // Byte FIFO status; the extra pointer bit tells full from empty.
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                        (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push       = msg_valid && !w_fifo_full;
  assign w_head       = r_fifo[r_rd_ptr[PW-1:0]];

  // A bit is available either from the shift register or directly from the FIFO head,
  // so the first pop of a run does not need a preload bubble.
  assign w_bit_avail  = r_sh_valid || !w_fifo_empty;
  assign w_pop_ok     = enc_readfifo && w_bit_avail;
  assign w_pop_err    = enc_readfifo && !w_bit_avail;

  // A FIFO byte is consumed when the shift register is empty or its last bit is popped.
  // Bits left over at the end of a run are discarded rather than pulling a new byte.
  assign w_fifo_pop   = w_pop_ok && !w_fifo_empty && (r_state != ST_FIN) &&
                        (!r_sh_valid || (r_idx == 3'd0));

  assign enc_bin_msg   = r_sh_valid ? r_shift[r_idx] : (!w_fifo_empty && w_head[7]);
  assign enc_fifoempty = !w_bit_avail;
  assign msg_ready     = !w_fifo_full;

  // Position accumulator starts at 0x7FF (-1) so the first position equals the first word.
  // That first addition always carries out of bit 10, so a carry only signals an overflow
  // from the second word on.
  assign w_sum      = {1'b0, r_pos_acc} + {1'b0, enc_cw_word} + 12'd1;
  assign w_overflow = w_sum[11] && (r_count != '0);
  assign w_last     = (r_count == CW'(T - 1));
  assign w_ram_we   = (r_state == ST_RUN) && enc_ready;

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign enc_start = r_enc_start;
  assign rd_data   = r_rd_data;

`ifdef CW_CTRL_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);

  logic [WDW-1:0] r_wdog;
  logic           w_wdog_active;
  logic           w_wdog_kick;

  assign w_wdog_active = (r_state == ST_RUN) || (r_state == ST_WAIT_DONE);
  assign w_wdog_kick   = enc_readfifo || enc_ready;
  assign w_wdog_expire = w_wdog_active && !w_wdog_kick &&
                         (r_wdog == WDW'(WDOG_CYC - 1));

  // Stall counter: runs while waiting on the encoder, restarts on any encoder activity.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wdog <= '0;
    end else if (!w_wdog_active || w_wdog_kick) begin
      r_wdog <= '0;
    end else if (r_wdog != WDW'(WDOG_CYC)) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  // Without the watchdog the controller waits indefinitely; this is always false.
  assign w_wdog_expire = (WDOG_CYC < 0);
`endif

  // Message FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[PW-1:0]] <= msg_data;
    end
  end

  // Message FIFO pointers; pushes are accepted in every state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Serialiser: walks the current byte from bit 7 down and reloads on the same edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_shift    <= '0;
      r_idx      <= 3'd7;
      r_sh_valid <= 1'b0;
    end else if (r_state == ST_FIN) begin
      r_idx      <= 3'd7;
      r_sh_valid <= 1'b0;
    end else if (w_pop_ok) begin
      if (!r_sh_valid) begin
        r_shift    <= w_head;
        r_idx      <= 3'd6;
        r_sh_valid <= 1'b1;
      end else if (r_idx == 3'd0) begin
        r_idx <= 3'd7;
        if (!w_fifo_empty) begin
          r_shift    <= w_head;
          r_sh_valid <= 1'b1;
        end else begin
          r_sh_valid <= 1'b0;
        end
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  // Run sequencer with registered handshake outputs, position accumulation and error capture.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_enc_start <= 1'b0;
      r_count     <= '0;
      r_pos_acc   <= 11'h7FF;
    end else begin
      r_done      <= 1'b0;
      r_enc_start <= 1'b0;
      if (w_pop_err) begin
        r_error <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_state     <= ST_START;
            r_busy      <= 1'b1;
            r_enc_start <= 1'b1;
            r_count     <= '0;
            r_pos_acc   <= 11'h7FF;
            r_error     <= 1'b0;
          end
        end
        ST_START: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (enc_ready) begin
            r_pos_acc <= w_sum[10:0];
            r_count   <= r_count + 1'b1;
            if (w_overflow) begin
              r_error <= 1'b1;
            end
          end
          if (enc_ready && w_last) begin
            if (enc_done) begin
              r_state <= ST_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_WAIT_DONE;
            end
          end else if (enc_done) begin
            r_error <= 1'b1;
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_wdog_expire) begin
            r_error <= 1'b1;
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (enc_ready) begin
            r_error <= 1'b1;
          end
          if (enc_done) begin
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_wdog_expire) begin
            r_error <= 1'b1;
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Position RAM write port; only words captured in RUN are stored.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[r_count] <= w_sum[10:0];
    end
  end

  // Registered readback; indices past the last position read as zero.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rd_data <= '0;
    end else if (rd_addr < 5'(T)) begin
      r_rd_data <= r_ram[rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

endmodule
